// File: rtl/pad_attr_cfg_pkg.sv
// Shared types for the pad-attribute configuration sequencer: pad types,
// per-type capability masks and the sequencer state encoding.
package pad_attr_cfg_pkg;

   typedef enum logic [2:0] {
      PadTypeGeneric = 3'b000,
      PadTypeDio     = 3'b001,
      PadTypeAnalog  = 3'b010,
      PadTypeOpenDr  = 3'b011
   } pad_type_e;

   typedef enum logic [1:0] {
      CfgIdle   = 2'd0,
      CfgCheck  = 2'd1,
      CfgApply  = 2'd2,
      CfgSettle = 2'd3
   } cfg_state_e;

   localparam int unsigned CapMaskW = 32;

   // Attribute bits a pad type physically implements; all others must be zero.
   function automatic logic [CapMaskW-1:0] cap_mask(input pad_type_e pad_type);
      logic [CapMaskW-1:0] mask;
      case (pad_type)
         PadTypeGeneric: mask = 32'h0000_FFFF;
         PadTypeDio:     mask = 32'h0000_00FF;
         PadTypeAnalog:  mask = 32'h0000_0003;
         PadTypeOpenDr:  mask = 32'h0000_001F;
         default:        mask = 32'h0000_0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/pad_attr_rr_arb.sv
// Two-way round-robin arbiter (index 0 = sw, 1 = dbg); the pointer remembers
// the last granted side so a tie goes to the other one.
module pad_attr_rr_arb
   import pad_attr_cfg_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] win_o,
   output logic       adv_o
);

   logic last_dbg_q;
   logic last_dbg_d;

   always_comb begin
      win_o = 2'b00;
      if (req_i == 2'b11) begin
         win_o = last_dbg_q ? 2'b01 : 2'b10;
      end else begin
         win_o = req_i;
      end
   end

   assign adv_o = en_i & (|req_i);
   assign last_dbg_d = adv_o ? win_o[1] : last_dbg_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_dbg_q <= 1'b0;
      end else begin
         last_dbg_q <= last_dbg_d;
      end
   end

endmodule

// File: rtl/pad_attr_cfg_ctrl.sv
// Pad-attribute write sequencer: arbitrates sw/dbg writes, legalises them
// against the bank's capability mask and holds off for a settle interval.
// Optional per-pad write locks are built when PAD_ATTR_CFG_LOCK_EN is defined.
//
// state     | meaning
// CfgIdle   | waiting for a request; done_o/err_o pulse here after a transaction
// CfgCheck  | grant pulse, index / lock legality check
// CfgApply  | masked attribute written into the target slice
// CfgSettle | settle down-counter running before the next write
module pad_attr_cfg_ctrl
   import pad_attr_cfg_pkg::*;
#(
   parameter int unsigned      NumPads      = 4,
   parameter int unsigned      AttrW        = 32,
   parameter logic [2:0]       PadType      = 3'b001,
   parameter logic [AttrW-1:0] ResetAttr    = 32'd1,
   parameter int unsigned      SettleCycles = 3
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       sw_req_i,
   input  logic [$clog2(NumPads):0]   sw_pad_idx_i,
   input  logic [AttrW-1:0]           sw_attr_i,
   output logic                       sw_gnt_o,
   input  logic                       dbg_req_i,
   input  logic [$clog2(NumPads):0]   dbg_pad_idx_i,
   input  logic [AttrW-1:0]           dbg_attr_i,
   output logic                       dbg_gnt_o,
`ifdef PAD_ATTR_CFG_LOCK_EN
   input  logic [NumPads-1:0]         lock_set_i,
`endif
   output logic [NumPads*AttrW-1:0]   attr_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       err_o
);

   localparam int unsigned IdxW = $clog2(NumPads) + 1;
   localparam int unsigned CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
   localparam logic [CntW-1:0] SettleLoad =
      (SettleCycles > 0) ? CntW'(SettleCycles - 1) : '0;
   localparam logic [AttrW-1:0] AttrMask = AttrW'(cap_mask(pad_type_e'(PadType)));

   cfg_state_e state_q, state_d;
   logic [CntW-1:0]               cnt_q, cnt_d;
   logic [IdxW-1:0]               idx_q;
   logic [AttrW-1:0]              attr_q;
   logic                          sel_dbg_q;
   logic                          done_q, done_d;
   logic                          err_q, err_d;
   logic [NumPads-1:0][AttrW-1:0] bank_q;

   logic [1:0]         arb_win;
   logic               arb_adv;
   logic [NumPads-1:0] pad_hit;
   logic               idx_err;
   logic               lock_err;
   logic               mask_err;

   pad_attr_rr_arb u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (state_q == CfgIdle),
      .req_i ({dbg_req_i, sw_req_i}),
      .win_o (arb_win),
      .adv_o (arb_adv)
   );

   always_comb begin
      pad_hit = '0;
      for (int k = 0; k < NumPads; k++) begin
         pad_hit[k] = (idx_q == IdxW'(k));
      end
   end

   assign idx_err  = (idx_q >= IdxW'(NumPads));
   assign mask_err = |(attr_q & ~AttrMask);

`ifdef PAD_ATTR_CFG_LOCK_EN
   logic [NumPads-1:0] lock_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lock_q <= '0;
      end else begin
         lock_q <= lock_q | lock_set_i;
      end
   end

   assign lock_err = |(pad_hit & lock_q);
`else
   assign lock_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         CfgIdle: begin
            if (arb_adv) state_d = CfgCheck;
         end
         CfgCheck: begin
            if (idx_err || lock_err) begin
               state_d = CfgIdle;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else begin
               state_d = CfgApply;
            end
         end
         CfgApply: begin
            if (SettleCycles == 0) begin
               state_d = CfgIdle;
               done_d  = 1'b1;
               err_d   = mask_err;
            end else begin
               state_d = CfgSettle;
               cnt_d   = SettleLoad;
            end
         end
         CfgSettle: begin
            if (cnt_q == '0) begin
               state_d = CfgIdle;
               done_d  = 1'b1;
               err_d   = mask_err;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = CfgIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= CfgIdle;
         cnt_q     <= '0;
         idx_q     <= '0;
         attr_q    <= '0;
         sel_dbg_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         if (state_q == CfgIdle && arb_adv) begin
            sel_dbg_q <= arb_win[1];
            idx_q     <= arb_win[1] ? dbg_pad_idx_i : sw_pad_idx_i;
            attr_q    <= arb_win[1] ? dbg_attr_i : sw_attr_i;
         end
      end
   end

   // CfgApply is only reached with a legal index, so exactly one slice is hit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bank_q <= {NumPads{ResetAttr}};
      end else if (state_q == CfgApply) begin
         for (int k = 0; k < NumPads; k++) begin
            if (pad_hit[k]) bank_q[k] <= attr_q & AttrMask;
         end
      end
   end

   assign attr_o    = bank_q;
   assign busy_o    = (state_q != CfgIdle);
   assign done_o    = done_q;
   assign err_o     = err_q;
   assign sw_gnt_o  = (state_q == CfgCheck) && !sel_dbg_q;
   assign dbg_gnt_o = (state_q == CfgCheck) && sel_dbg_q;

endmodule

// File: tb/tb_pad_attr_cfg_ctrl.sv
// Self-checking bench for pad_attr_cfg_ctrl: directed and random writes checked
// cycle by cycle against a transaction-level model (lock test with PAD_ATTR_CFG_LOCK_EN).
module tb_pad_attr_cfg_ctrl;

   localparam int          NumPads  = 4;
   localparam int          Settle   = 3;
   localparam logic [31:0] Mask     = 32'h0000_00FF;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sw_req = 1'b0, dbg_req = 1'b0;
   logic [2:0]   sw_idx = '0, dbg_idx = '0;
   logic [31:0]  sw_attr = '0, dbg_attr = '0;
   logic         sw_gnt, dbg_gnt, busy, done, err;
   logic [127:0] attr;
`ifdef PAD_ATTR_CFG_LOCK_EN
   logic [3:0]   lock_set = '0;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] m_bank [NumPads];
   bit          m_last_dbg;
   bit          m_lock [NumPads];

   always #5 clk = ~clk;

   pad_attr_cfg_ctrl #(
      .NumPads(NumPads), .AttrW(32), .PadType(3'b001),
      .ResetAttr(32'd1), .SettleCycles(Settle)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .sw_req_i(sw_req), .sw_pad_idx_i(sw_idx), .sw_attr_i(sw_attr), .sw_gnt_o(sw_gnt),
      .dbg_req_i(dbg_req), .dbg_pad_idx_i(dbg_idx), .dbg_attr_i(dbg_attr), .dbg_gnt_o(dbg_gnt),
`ifdef PAD_ATTR_CFG_LOCK_EN
      .lock_set_i(lock_set),
`endif
      .attr_o(attr), .busy_o(busy), .done_o(done), .err_o(err)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [127:0] model_bank();
      logic [127:0] v;
      for (int k = 0; k < NumPads; k++) v[k*32 +: 32] = m_bank[k];
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NumPads; k++) begin
         m_bank[k] = 32'd1;
         m_lock[k] = 1'b0;
      end
      m_last_dbg = 1'b0;
   endtask

   function automatic bit rejected(input logic [2:0] idx);
      if (idx >= NumPads) return 1'b1;
      return m_lock[idx];
   endfunction

   function automatic int txn_len(input logic [2:0] idx);
      return rejected(idx) ? 2 : 3 + Settle;
   endfunction

   function automatic bit txn_err(input logic [2:0] idx, input logic [31:0] a);
      return rejected(idx) || ((a & ~Mask) != 0);
   endfunction

   // One or two simultaneous requests; cycle 1 is the first cycle after req is sampled.
   task automatic run_txn(input bit s_en, input logic [2:0] s_idx, input logic [31:0] s_attr,
                          input bit d_en, input logic [2:0] d_idx, input logic [31:0] d_attr);
      bit two, first_dbg;
      logic [2:0] i1, i2;
      logic [31:0] a1, a2;
      bit r1, r2, e1, e2, exp_sg, exp_dg, exp_done, exp_err;
      int d1, d2, end_c;
      if (!s_en && !d_en) return;
      @(negedge clk);
      sw_req = s_en;   sw_idx = s_idx;   sw_attr = s_attr;
      dbg_req = d_en;  dbg_idx = d_idx;  dbg_attr = d_attr;
      two = s_en && d_en;
      first_dbg = two ? !m_last_dbg : d_en;
      i1 = first_dbg ? d_idx : s_idx;   a1 = first_dbg ? d_attr : s_attr;
      i2 = first_dbg ? s_idx : d_idx;   a2 = first_dbg ? s_attr : d_attr;
      r1 = rejected(i1);  e1 = txn_err(i1, a1);  d1 = txn_len(i1);
      r2 = rejected(i2);  e2 = txn_err(i2, a2);  d2 = d1 + txn_len(i2);
      m_last_dbg = two ? !first_dbg : first_dbg;
      end_c = two ? d2 : d1;
      for (int c = 1; c <= end_c; c++) begin
         @(negedge clk);
         if (c == 3 && !r1) m_bank[i1[1:0]] = a1 & Mask;
         if (two && c == d1 + 3 && !r2) m_bank[i2[1:0]] = a2 & Mask;
         exp_sg   = (c == 1 && !first_dbg) || (two && c == d1 + 1 && first_dbg);
         exp_dg   = (c == 1 && first_dbg) || (two && c == d1 + 1 && !first_dbg);
         exp_done = (c == d1) || (two && c == d2);
         exp_err  = (c == d1 && e1) || (two && c == d2 && e2);
         chk("sw_gnt", sw_gnt, exp_sg);
         chk("dbg_gnt", dbg_gnt, exp_dg);
         chk("done", done, exp_done);
         chk("err", err, exp_err);
         chk("busy", busy, !exp_done);
         chk("attr", attr, model_bank());
         if (exp_sg) sw_req = 1'b0;
         if (exp_dg) dbg_req = 1'b0;
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rst_attr", attr, {4{32'd1}});
         chk("rst_busy", busy, 1'b0);
         chk("rst_pulses", {sw_gnt, dbg_gnt, done, err}, 4'b0000);
      end

      run_txn(1'b1, 3'd0, 32'h0000_0011, 1'b1, 3'd3, 32'h0000_0033);
      run_txn(1'b1, 3'd2, 32'h0000_00A5, 1'b0, 3'd0, 32'h0);
      run_txn(1'b1, 3'd1, 32'h1234_5601, 1'b0, 3'd0, 32'h0);
      run_txn(1'b0, 3'd0, 32'h0, 1'b1, 3'd5, 32'h0000_0042);
      run_txn(1'b1, 3'd4, 32'h0000_0001, 1'b1, 3'd2, 32'h0000_FF7E);
      run_txn(1'b1, 3'd3, 32'h0000_00C3, 1'b1, 3'd0, 32'h0000_003C);

      for (int t = 0; t < 50; t++) begin
         bit se, de;
         logic [2:0] si, di;
         logic [31:0] sa, da;
         se = 1'($urandom_range(0, 1));
         de = se ? 1'($urandom_range(0, 1)) : 1'b1;
         si = 3'($urandom_range(0, 7));
         di = 3'($urandom_range(0, 7));
         sa = ($urandom_range(0, 1) != 0) ? ($urandom & Mask) : $urandom;
         da = ($urandom_range(0, 1) != 0) ? ($urandom & Mask) : $urandom;
         run_txn(se, si, sa, de, di, da);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Reset while settling: the transaction is dropped without completion.
      @(negedge clk);
      sw_req = 1'b1; sw_idx = 3'd3; sw_attr = 32'h0000_005A;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) sw_req = 1'b0;
         if (c == 3) chk("pre_rst_slice3", attr[96 +: 32], 32'h0000_005A);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk("mid_rst_attr", attr, {4{32'd1}});
      chk("mid_rst_busy", busy, 1'b0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("post_rst_done", {done, err}, 2'b00);
         chk("post_rst_attr", attr, model_bank());
      end

      run_txn(1'b1, 3'd0, 32'h0000_0077, 1'b1, 3'd1, 32'h0000_0088);

`ifdef PAD_ATTR_CFG_LOCK_EN
      @(negedge clk);
      lock_set = 4'b0001;
      @(negedge clk);
      lock_set = 4'b0000;
      m_lock[0] = 1'b1;
      run_txn(1'b1, 3'd0, 32'h0000_0055, 1'b0, 3'd0, 32'h0);
      run_txn(1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 32'h0000_0066);
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pad_attr_cfg_ctrl.md
Name: pad_attr_cfg_ctrl

Overview:
- Sequences attribute writes into a bank of pad-attribute registers that drive the `attr` inputs of the per-pad `prim_pad_attr` instances in the DIO generate loop.
- Arbitrates round-robin between two requesters: software (sw) and debug/test (dbg).
- Legalises each write against a per-pad-type capability mask, then enforces a settle interval before the next write is accepted.
- Sits between the pad-control register file and the pad wrapper.

Parameters:
- NumPads, 4, number of pads in the bank.
- AttrW, 32, width of one pad attribute word.
- PadType, 3'b001, pad type of the bank; selects the capability mask from the package.
- ResetAttr, 32'd1, reset value of every pad attribute word.
- SettleCycles, 3, idle cycles after each applied write; 0 is legal.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- sw_req_i  in  1  sw write request; held until sw_gnt_o.
- sw_pad_idx_i  in  $clog2(NumPads)+1  target pad index, sw.
- sw_attr_i  in  AttrW  attribute value, sw.
- sw_gnt_o  out  1  one-cycle grant pulse, sw.
- dbg_req_i  in  1  dbg write request; held until dbg_gnt_o.
- dbg_pad_idx_i  in  $clog2(NumPads)+1  target pad index, dbg.
- dbg_attr_i  in  AttrW  attribute value, dbg.
- dbg_gnt_o  out  1  one-cycle grant pulse, dbg.
- attr_o  out  NumPads*AttrW  attribute bank; pad k occupies bits [k*AttrW +: AttrW].
- busy_o  out  1  high whenever FSM state is not IDLE.
- done_o  out  1  one-cycle pulse when a transaction completes.
- err_o  out  1  one-cycle pulse, coincident with done_o, when the transaction had an error.

Behaviour:

Reset (rst_i sampled high at a clock edge):
- attr_o = ResetAttr replicated NumPads times.
- gnt/done/err outputs = 0.
- FSM = IDLE; round-robin pointer = sw (dbg wins the first tie).
- Reset mid-transaction aborts it with no done_o.

FSM states: IDLE, CHECK, APPLY, SETTLE. Transitions:
- IDLE:
  - If either req is high, pick the winner.
  - If both are high, pick the side not granted last; then flip the pointer.
  - Capture the winner's index and attr into registers; go to CHECK.
- CHECK (1 cycle):
  - Winner's gnt_o is high during this cycle only.
  - Compute idx_err = (idx >= NumPads).
  - Compute mask_err = |(attr & ~CapMask[PadType]).
  - If idx_err: go to IDLE, pulse done_o and err_o on entry, no register write.
  - Otherwise go to APPLY.
- APPLY (1 cycle):
  - attr_o slice[idx] <= attr & CapMask[PadType] at the end of the cycle.
  - Other slices are unchanged.
  - Go to SETTLE if SettleCycles > 0, else go to IDLE.
- SETTLE:
  - A down-counter loaded with SettleCycles-1 decrements each cycle.
  - At 0, go to IDLE.
- Completion: done_o pulses in the first IDLE cycle after a transaction; err_o = mask_err in that same cycle.

Timing and handshake:
- Latency: req seen at cycle N, gnt_o at N+1, attr_o updated at N+3, done_o at N+3+SettleCycles.
- Requesters must keep req and payload stable until gnt_o, and drop req the cycle after gnt_o.
- A req still high after that is treated as a new transaction.
- A req arriving while busy_o is high waits; it is never dropped.
- Throughput: one write per 3+SettleCycles cycles.
- IDLE may accept a new request in the same cycle that done_o pulses.

Optional Feature:
- Macro: PAD_ATTR_CFG_LOCK_EN.
- With the macro:
  - Adds input port lock_set_i, width NumPads.
  - Per-pad sticky lock bits are set by lock_set_i and cleared only by rst_i.
  - A write to a locked pad is rejected in CHECK like idx_err: no write, done_o and err_o pulse.
  - lock_set_i asserted in the same cycle as APPLY to that pad: the write still lands, and the lock takes effect afterwards.
- Without the macro: no lock port, no lock bits.

Decomposition:
- Package pad_attr_cfg_pkg holds:
  - pad_type_e (3-bit pad type enum);
  - CapMask lookup function indexed by pad type;
  - state enum cfg_state_e.
- One sub-module, pad_attr_rr_arb: 2-way round-robin arbiter with a pointer, producing a one-hot winner and an advance strobe.

Test Plan:
All scenarios use AttrMask = CapMask[3'b001] = 32'h0000_00FF and SettleCycles = 3.
1. Reset, then no requests: attr_o = {4{32'd1}}, busy_o = 0, no pulses.
2. sw writes idx=2, attr=32'h0000_00A5 at cycle 0: sw_gnt_o at cycle 1; slice 2 = 32'hA5 at cycle 3; done_o at cycle 6 with err_o = 0.
3. sw and dbg both request at cycle 0 right after reset: dbg granted first, and sw is granted when IDLE is next entered (pointer alternates; dbg is not regranted while sw waits).
4. sw writes idx=1, attr=32'h1234_5601: slice 1 = 32'h0000_0001; err_o and done_o pulse together.
5. dbg writes idx=5: no slice changes; done_o and err_o pulse at cycle 2; busy_o drops at cycle 2.
6. rst_i asserted during SETTLE: outputs return to reset values next cycle, no done_o; with PAD_ATTR_CFG_LOCK_EN, lock pad 0 and then write pad 0 → slice 0 unchanged, err_o pulses.
